// File: rtl/imm_ext_pkg.sv
// Shared constants for the pipelined immediate extender: mode encodings and
// default datapath widths.
package imm_ext_pkg;

  localparam int unsigned SRC_W        = 3;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned X_W_DEF      = 24;
  localparam int unsigned BR_SHIFT_DEF = 2;

  localparam logic [SRC_W-1:0] IMM8_U   = 3'b000;
  localparam logic [SRC_W-1:0] IMM12_U  = 3'b001;
  localparam logic [SRC_W-1:0] BRANCH   = 3'b010;
  localparam logic [SRC_W-1:0] ROT_IMM8 = 3'b011;
  localparam logic [SRC_W-1:0] IMM12_S  = 3'b100;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate decode/extension: produces the extended value, the
// shifter carry and the undefined-mode flag from one raw immediate field.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned X_W      = X_W_DEF,
  parameter int unsigned BR_SHIFT = BR_SHIFT_DEF
) (
  input  logic [X_W-1:0]    x,
  input  logic [SRC_W-1:0]  src,
  input  logic              carry_in,
  output logic [DATA_W-1:0] y_c,
  output logic              carry_out_c,
  output logic              err_c
);

  logic [DATA_W-1:0] imm8;
  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] br;
  logic [4:0]        rot_amt;

  // Rotation is done on a doubled copy so the wrapped bits fall into the low half.
  always_comb begin
    imm8    = DATA_W'(x[7:0]);
    rot_amt = {x[11:8], 1'b0};
    rot     = DATA_W'({imm8, imm8} >> rot_amt);
    br      = DATA_W'({{DATA_W{x[X_W-1]}}, x} << BR_SHIFT);
  end

  always_comb begin
    y_c         = '0;
    carry_out_c = carry_in;
    err_c       = 1'b0;
    case (src)
      IMM8_U:   y_c = imm8;
      IMM12_U:  y_c = DATA_W'(x[11:0]);
      BRANCH:   y_c = br;
      ROT_IMM8: begin
        y_c = rot;
        if (rot_amt != 5'd0) carry_out_c = rot[DATA_W-1];
      end
      IMM12_S:  y_c = {{(DATA_W-12){x[11]}}, x[11:0]};
      default:  err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready pipeline around imm_ext_core: stage 1 captures the raw
// request, stage 2 registers the extended result with its tag.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned X_W      = X_W_DEF,
  parameter int unsigned BR_SHIFT = BR_SHIFT_DEF,
  parameter int unsigned TAG_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    x,
  input  logic [SRC_W-1:0]  src,
  input  logic              carry_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic              carry_out,
  output logic              err,
  output logic [TAG_W-1:0]  tag_out
);

  logic              s1_valid;
  logic [X_W-1:0]    s1_x;
  logic [SRC_W-1:0]  s1_src;
  logic              s1_carry;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_ready;
  logic              s1_ready;
  logic [DATA_W-1:0] core_y;
  logic              core_carry;
  logic              core_err;

  // Ready chain: each stage can take data if it is empty or draining this cycle.
  always_comb begin
    s2_ready = !out_valid || out_ready;
    s1_ready = !s1_valid || s2_ready;
    in_ready = s1_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_src   <= '0;
      s1_carry <= 1'b0;
      s1_tag   <= '0;
    end else if (in_valid && s1_ready) begin
      s1_valid <= 1'b1;
      s1_x     <= x;
      s1_src   <= src;
      s1_carry <= carry_in;
      s1_tag   <= tag_in;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  imm_ext_core #(
    .DATA_W   (DATA_W),
    .X_W      (X_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .x           (s1_x),
    .src         (s1_src),
    .carry_in    (s1_carry),
    .y_c         (core_y),
    .carry_out_c (core_carry),
    .err_c       (core_err)
  );

  // Output register holds its value while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
      tag_out   <= '0;
    end else if (s1_valid && s2_ready) begin
      out_valid <= 1'b1;
      y         <= core_y;
      carry_out <= core_carry;
      err       <= core_err;
      tag_out   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed mode vectors, back-pressure,
// mid-stream reset and randomized traffic against an arithmetic reference model.
module tb_imm_extend_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned X_W    = 24;
  localparam int unsigned TAG_W  = 4;
  localparam int          BOUND  = 200;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              c;
    logic              e;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [X_W-1:0]    x = '0;
  logic [2:0]        src = '0;
  logic              carry_in = 1'b0;
  logic [TAG_W-1:0]  tag_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] y;
  logic              carry_out;
  logic              err;
  logic [TAG_W-1:0]  tag_out;

  int   errors = 0;
  int   checks = 0;
  bit   rand_bp = 1'b0;
  logic or_hold = 1'b1;
  exp_t exp_q[$];

  imm_extend_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .src       (src),
    .carry_in  (carry_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry_out (carry_out),
    .err       (err),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] yv, input logic cv, input logic ev,
                              input logic [3:0] tv);
    exp_t e;
    e.y = yv; e.c = cv; e.e = ev; e.tag = tv;
    return e;
  endfunction

  // Reference model: modes computed with plain integer arithmetic.
  function automatic exp_t model(input logic [23:0] xv, input logic [2:0] sv,
                                 input logic cv, input logic [3:0] tv);
    exp_t        e;
    longint      v;
    int          r;
    logic [31:0] w;
    e.tag = tv; e.c = cv; e.e = 1'b0; e.y = '0;
    v = longint'(xv);
    case (sv)
      3'd0: e.y = 32'(v % 256);
      3'd1: e.y = 32'(v % 4096);
      3'd2: begin
        if (v >= 8388608) v = v - 16777216;
        e.y = 32'(v * 4);
      end
      3'd3: begin
        w = 32'(v % 256);
        r = 2 * int'((v / 256) % 16);
        for (int i = 0; i < r; i++) w = {w[0], w[31:1]};
        e.y = w;
        if (r != 0) e.c = w[31];
      end
      3'd4: begin
        v = v % 4096;
        if (v >= 2048) v = v - 4096;
        e.y = 32'(v);
      end
      default: e.e = 1'b1;
    endcase
    return e;
  endfunction

  // Back-pressure generator.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : or_hold;
  end

  // Monitor: pops the scoreboard on each consume and checks held values on stalls.
  initial begin : monitor
    bit   stalled;
    exp_t held;
    exp_t e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_y", 64'(y), 64'(held.y));
          chk("hold_tag", 64'(tag_out), 64'(held.tag));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: tag 0x%0h y 0x%0h with empty scoreboard", tag_out, y);
          end else begin
            e = exp_q.pop_front();
            chk("out_y", 64'(y), 64'(e.y));
            chk("out_carry", 64'(carry_out), 64'(e.c));
            chk("out_err", 64'(err), 64'(e.e));
            chk("out_tag", 64'(tag_out), 64'(e.tag));
          end
        end
        stalled = out_valid && !out_ready;
        held    = mk(y, carry_out, err, tag_out);
      end
    end
  end

  // Issue one request and wait (bounded) for its acceptance edge; returns at edge+1.
  task automatic send(input logic [23:0] xv, input logic [2:0] sv, input logic cv,
                      input logic [3:0] tv, input exp_t e);
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    x = xv; src = sv; carry_in = cv; tag_in = tv; in_valid = 1'b1;
    exp_q.push_back(e);
    while (!ok && n < BOUND) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tag %0d got no in_ready, expected acceptance within %0d cycles", tv, BOUND);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : main
    logic [23:0] xv;
    logic [2:0]  sv;
    logic        cv;
    logic [3:0]  tv;

    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_carry", 64'(carry_out), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_tag", 64'(tag_out), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed mode vectors; first one also checks the two-register latency.
    send(24'h1234AB, 3'b000, 1'b0, 4'd1, mk(32'h000000AB, 1'b0, 1'b0, 4'd1));
    chk("lat_after_accept", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("lat_next_edge", 64'(out_valid), 64'(1));
    chk("lat_y", 64'(y), 64'(32'h000000AB));
    send(24'h000ABC, 3'b001, 1'b0, 4'd2, mk(32'h00000ABC, 1'b0, 1'b0, 4'd2));
    send(24'hFFFFFE, 3'b010, 1'b0, 4'd3, mk(32'hFFFFFFF8, 1'b0, 1'b0, 4'd3));
    send(24'h000001, 3'b010, 1'b1, 4'd4, mk(32'h00000004, 1'b1, 1'b0, 4'd4));
    send(24'h000800, 3'b100, 1'b0, 4'd5, mk(32'hFFFFF800, 1'b0, 1'b0, 4'd5));
    send(24'h0004FF, 3'b011, 1'b0, 4'd6, mk(32'hFF000000, 1'b1, 1'b0, 4'd6));
    send(24'h0000FF, 3'b011, 1'b1, 4'd7, mk(32'h000000FF, 1'b1, 1'b0, 4'd7));
    send(24'hFFFFFF, 3'b111, 1'b1, 4'd8, mk(32'h00000000, 1'b1, 1'b1, 4'd8));
    send(24'hFFFFFF, 3'b101, 1'b0, 4'd9, mk(32'h00000000, 1'b0, 1'b1, 4'd9));
    drain("directed_drain");

    // Back-pressure: two accepts fill the pipe, then the output must hold tag 1.
    or_hold = 1'b0;
    for (int t = 1; t <= 2; t++)
      send(24'(t), 3'b000, 1'b0, 4'(t), model(24'(t), 3'b000, 1'b0, 4'(t)));
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_tag_stable", 64'(tag_out), 64'(1));
    end
    @(posedge clk);
    #1;
    or_hold = 1'b1;
    for (int t = 3; t <= 6; t++)
      send(24'(t), 3'b000, 1'b0, 4'(t), model(24'(t), 3'b000, 1'b0, 4'(t)));
    drain("bp_drain");

    // Reset with both stages full: outputs clear at once, nothing stale afterwards.
    or_hold = 1'b0;
    send(24'h0000AA, 3'b000, 1'b0, 4'd10, model(24'h0000AA, 3'b000, 1'b0, 4'd10));
    send(24'h0000BB, 3'b000, 1'b0, 4'd11, model(24'h0000BB, 3'b000, 1'b0, 4'd11));
    chk("rs_full_in_ready", 64'(in_ready), 64'(0));
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("rs_out_valid", 64'(out_valid), 64'(0));
    chk("rs_y", 64'(y), 64'(0));
    chk("rs_tag", 64'(tag_out), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    or_hold = 1'b1;
    chk("rs_in_ready", 64'(in_ready), 64'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rs_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random gaps and random back-pressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      xv = 24'($urandom);
      sv = 3'($urandom_range(0, 7));
      cv = 1'($urandom_range(0, 1));
      tv = 4'(i);
      send(xv, sv, cv, tv, model(xv, sv, cv, tv));
    end
    rand_bp = 1'b0;
    or_hold = 1'b1;
    drain("rand_drain");
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
